// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: per-pipe execute results in, one registered writeback result out.
// master = result producers / writeback consumer side, slave = the arbiter.
interface writeback_arbiter_if #(
   parameter int p_num_pipes      = 2,
   parameter int p_seq_num_bits   = 5,
   parameter int p_phys_addr_bits = 6
);
   logic [p_num_pipes-1:0]                  ex_val;
   logic [p_num_pipes-1:0]                  ex_rdy;
   logic [p_num_pipes*32-1:0]               ex_pc;
   logic [p_num_pipes*p_seq_num_bits-1:0]   ex_seq_num;
   logic [p_num_pipes*5-1:0]                ex_waddr;
   logic [p_num_pipes*p_phys_addr_bits-1:0] ex_preg;
   logic [p_num_pipes*32-1:0]               ex_wdata;
   logic [p_num_pipes-1:0]                  ex_wen;
   logic [p_seq_num_bits-1:0]               commit_head_seq;

   logic                                    wb_val;
   logic                                    wb_rdy;
   logic [31:0]                             wb_pc;
   logic [p_seq_num_bits-1:0]               wb_seq_num;
   logic [4:0]                              wb_waddr;
   logic [p_phys_addr_bits-1:0]             wb_preg;
   logic [31:0]                             wb_wdata;
   logic                                    wb_wen;

   modport master (
      output ex_val, ex_pc, ex_seq_num, ex_waddr, ex_preg, ex_wdata, ex_wen,
             commit_head_seq, wb_rdy,
      input  ex_rdy, wb_val, wb_pc, wb_seq_num, wb_waddr, wb_preg, wb_wdata, wb_wen
   );

   modport slave (
      input  ex_val, ex_pc, ex_seq_num, ex_waddr, ex_preg, ex_wdata, ex_wen,
             commit_head_seq, wb_rdy,
      output ex_rdy, wb_val, wb_pc, wb_seq_num, wb_waddr, wb_preg, wb_wdata, wb_wen
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter of N execute pipes onto one registered writeback port.
// Latency 1 cycle; ex_rdy only when output register is empty or draining (wb_rdy), else pipes stall.
// Optional WB_ARB_AGE_PRIORITY_EN: oldest result (relative to commit head) wins, ties in round-robin order.
module writeback_arbiter #(
   parameter int p_num_pipes      = 2,
   parameter int p_seq_num_bits   = 5,
   parameter int p_phys_addr_bits = 6
) (
   input  logic               clk,
   input  logic               rst,
   writeback_arbiter_if.slave bus
);
   localparam int PtrW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

   logic                        wb_val_q,   wb_val_d;
   logic [31:0]                 wb_pc_q,    wb_pc_d;
   logic [p_seq_num_bits-1:0]   wb_seq_q,   wb_seq_d;
   logic [4:0]                  wb_waddr_q, wb_waddr_d;
   logic [p_phys_addr_bits-1:0] wb_preg_q,  wb_preg_d;
   logic [31:0]                 wb_wdata_q, wb_wdata_d;
   logic                        wb_wen_q,   wb_wen_d;
   logic [PtrW-1:0]             rr_ptr_q,   rr_ptr_d;

   logic                        free;
   logic                        gnt_vld;
   logic [PtrW-1:0]             gnt_idx;
   logic                        xfer;
   logic [p_num_pipes-1:0]      gnt_onehot;

   assign free = !wb_val_q || bus.wb_rdy;

   // Walk pipes in round-robin order from rr_ptr; a strictly better candidate replaces the current one.
   always_comb begin
      int idx;
`ifdef WB_ARB_AGE_PRIORITY_EN
      logic [p_seq_num_bits-1:0] age;
      logic [p_seq_num_bits-1:0] best_age;
      age      = '0;
      best_age = '1;
`endif
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < p_num_pipes; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= p_num_pipes) idx = idx - p_num_pipes;
`ifdef WB_ARB_AGE_PRIORITY_EN
         age = bus.ex_seq_num[idx*p_seq_num_bits +: p_seq_num_bits] - bus.commit_head_seq;
         if (bus.ex_val[idx] && (!gnt_vld || age < best_age)) begin
            gnt_vld  = 1'b1;
            gnt_idx  = PtrW'(idx);
            best_age = age;
         end
`else
         if (bus.ex_val[idx] && !gnt_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = PtrW'(idx);
         end
`endif
      end
   end

`ifndef WB_ARB_AGE_PRIORITY_EN
   logic unused_head;
   assign unused_head = ^bus.commit_head_seq;
`endif

   assign xfer = gnt_vld && free && !rst;

   always_comb begin
      gnt_onehot = '0;
      if (xfer) gnt_onehot[gnt_idx] = 1'b1;
   end

   assign bus.ex_rdy = gnt_onehot;

   always_comb begin
      int sel;
      int nxt;
      sel = int'(gnt_idx);
      nxt = sel + 1;
      if (nxt >= p_num_pipes) nxt = 0;

      wb_val_d   = wb_val_q;
      wb_pc_d    = wb_pc_q;
      wb_seq_d   = wb_seq_q;
      wb_waddr_d = wb_waddr_q;
      wb_preg_d  = wb_preg_q;
      wb_wdata_d = wb_wdata_q;
      wb_wen_d   = wb_wen_q;
      rr_ptr_d   = rr_ptr_q;

      if (xfer) begin
         wb_val_d   = 1'b1;
         wb_pc_d    = bus.ex_pc[sel*32 +: 32];
         wb_seq_d   = bus.ex_seq_num[sel*p_seq_num_bits +: p_seq_num_bits];
         wb_waddr_d = bus.ex_waddr[sel*5 +: 5];
         wb_preg_d  = bus.ex_preg[sel*p_phys_addr_bits +: p_phys_addr_bits];
         wb_wdata_d = bus.ex_wdata[sel*32 +: 32];
         wb_wen_d   = bus.ex_wen[sel];
         rr_ptr_d   = PtrW'(nxt);
      end else if (bus.wb_rdy) begin
         wb_val_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_val_q   <= 1'b0;
         wb_pc_q    <= '0;
         wb_seq_q   <= '0;
         wb_waddr_q <= '0;
         wb_preg_q  <= '0;
         wb_wdata_q <= '0;
         wb_wen_q   <= 1'b0;
         rr_ptr_q   <= '0;
      end else begin
         wb_val_q   <= wb_val_d;
         wb_pc_q    <= wb_pc_d;
         wb_seq_q   <= wb_seq_d;
         wb_waddr_q <= wb_waddr_d;
         wb_preg_q  <= wb_preg_d;
         wb_wdata_q <= wb_wdata_d;
         wb_wen_q   <= wb_wen_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign bus.wb_val     = wb_val_q;
   assign bus.wb_pc      = wb_pc_q;
   assign bus.wb_seq_num = wb_seq_q;
   assign bus.wb_waddr   = wb_waddr_q;
   assign bus.wb_preg    = wb_preg_q;
   assign bus.wb_wdata   = wb_wdata_q;
   assign bus.wb_wen     = wb_wen_q;
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter p_num_pipes, default 2, number of execute pipes sharing the writeback port (2..8).
REQ-002 SHALL have parameter p_seq_num_bits, default 5, width of sequence numbers.
REQ-003 SHALL have parameter p_phys_addr_bits, default 6, width of physical register addresses.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ex_val  input  p_num_pipes  per-pipe result valid.
REQ-007 SHALL have port ex_rdy  output  p_num_pipes  per-pipe grant; transfer occurs when ex_val[i] && ex_rdy[i].
REQ-008 SHALL have ports ex_pc (32), ex_seq_num (p_seq_num_bits), ex_waddr (5), ex_preg (p_phys_addr_bits), ex_wdata (32), ex_wen (1)  input  packed per pipe, pipe i in slice i  result payload.
REQ-009 SHALL have port commit_head_seq  input  p_seq_num_bits  sequence number of oldest uncommitted instruction.
REQ-010 SHALL have port wb_val  output  1  registered result valid toward writeback/commit.
REQ-011 SHALL have port wb_rdy  input  1  writeback accepts when wb_val && wb_rdy.
REQ-012 SHALL have ports wb_pc, wb_seq_num, wb_waddr, wb_preg, wb_wdata, wb_wen  output  widths per REQ-008  registered payload of granted pipe.

Function
REQ-013 SHALL hold one output register (valid bit + payload); free = !wb_val || wb_rdy.
REQ-014 SHALL assert at most one ex_rdy bit per cycle, and only for a pipe with ex_val set, and only when free.
REQ-015 SHALL compute ex_rdy combinationally from ex_val, wb_val, wb_rdy and arbitration state; ex_rdy SHALL NOT depend on payload inputs except via REQ-025.
REQ-016 SHALL, on a transfer from pipe i, load pipe i payload into the output register and set wb_val next cycle (latency 1 cycle).
REQ-017 SHALL clear wb_val when wb_val && wb_rdy and no new transfer occurs that cycle; SHALL sustain 1 result/cycle when wb_rdy stays high.
REQ-018 SHALL keep wb payload stable while wb_val && !wb_rdy.
REQ-019 SHALL arbitrate round-robin: search starts at pointer rr_ptr, ascending with wrap-around from p_num_pipes-1 to 0; first valid pipe wins.
REQ-020 SHALL update rr_ptr to (granted index + 1) mod p_num_pipes after each transfer; rr_ptr unchanged when no transfer.
REQ-021 SHALL guarantee any pipe holding ex_val continuously is granted within p_num_pipes transfers.
REQ-022 SHALL grant nothing and hold state when all ex_val are 0 or output is not free.

Reset
REQ-023 SHALL, while rst is high at a clock edge, set wb_val=0, all wb payload=0, rr_ptr=0; ex_rdy SHALL be 0 while rst is high.
REQ-024 SHALL discard an in-flight output result when rst asserts mid-operation; no transfer is accepted in the reset cycle.

Configuration
REQ-025 SHALL, when macro WB_ARB_AGE_PRIORITY_EN is defined, grant the valid pipe with smallest age = (ex_seq_num - commit_head_seq) mod 2^p_seq_num_bits, ties broken by round-robin order of REQ-019; rr_ptr still updates per REQ-020.
REQ-026 SHALL, without WB_ARB_AGE_PRIORITY_EN, use pure round-robin and leave commit_head_seq unused.

Verification
REQ-027 SHALL cover: rst held 2 cycles with ex_val=2'b11 -> ex_rdy=0, wb_val=0, after release first grant pipe 0.
REQ-028 SHALL cover: both pipes valid continuously, wb_rdy=1, 6 cycles -> grants alternate 0,1,0,1,0,1; wb_val high from cycle after first grant.
REQ-029 SHALL cover: wb_rdy=0 with wb_val=1 for 3 cycles -> ex_rdy=0, wb payload (e.g. wdata=0xDEADBEEF) unchanged; wb_rdy=1 -> next grant same cycle.
REQ-030 SHALL cover: p_num_pipes=4, only pipe 3 valid then pipes 0 and 3 valid -> grant 3, then 0 (rr_ptr wrapped to 0).
REQ-031 SHALL cover (macro defined): commit_head_seq=30, pipe0 seq=2, pipe1 seq=31 -> pipe1 granted first (age 1 vs 4).
REQ-032 SHALL cover: rst asserted while wb_val=1, wb_rdy=0 -> wb_val=0 next cycle, no result emitted.
